// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready operand intake and a registered valid/ready result stage.
// Single-cycle ops load the output stage on accept; MUL runs a WIDTH-step shift-add first.
module alu_mc #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_op,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_zero,
    output logic             o_neg,
    output logic             o_ovf,
    output logic             o_busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t r_state;
    state_t w_stateNext;

    logic             r_outValid;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_zero;
    logic             r_neg;
    logic             r_ovf;

    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;

    logic               w_accept;
    logic               w_mulDone;
    logic [WIDTH:0]     w_sumAdd;
    logic [WIDTH:0]     w_sumSub;
    logic               w_bEffSign;
    logic [SHW-1:0]     w_shamt;
    logic [WIDTH-1:0]   w_res;
    logic               w_carry;
    logic               w_ovf;
    logic [2*WIDTH-1:0] w_prodAdd;

    assign o_in_ready = rst_n & (r_state == S_IDLE) & (~r_outValid | i_out_ready);
    assign w_accept   = i_in_valid & o_in_ready;
    assign w_mulDone  = (r_state == S_MUL) && (r_cnt == CW'(WIDTH));
    assign w_prodAdd  = r_mplier[0] ? (r_prod + r_mcand) : r_prod;

    always_comb begin
        w_sumAdd = {1'b0, i_a} + {1'b0, i_b};
        w_sumSub = {1'b0, i_a} - {1'b0, i_b};
        w_shamt  = i_b[SHW-1:0];
        // Sign of the two's-complement negation of b: only an all-zero low part keeps b's sign.
        if (i_op == OP_SUB) begin
            w_bEffSign = (i_b[WIDTH-2:0] == '0) ? i_b[WIDTH-1] : ~i_b[WIDTH-1];
        end else begin
            w_bEffSign = i_b[WIDTH-1];
        end
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_res   = w_sumAdd[WIDTH-1:0];
                w_carry = w_sumAdd[WIDTH];
            end
            OP_SUB: begin
                w_res   = w_sumSub[WIDTH-1:0];
                w_carry = w_sumSub[WIDTH];
            end
            OP_AND:  w_res = i_a & i_b;
            OP_OR:   w_res = i_a | i_b;
            OP_XOR:  w_res = i_a ^ i_b;
            OP_SLL:  w_res = i_a << w_shamt;
            OP_SRL:  w_res = i_a >> w_shamt;
            default: w_res = '0;
        endcase
        if ((i_op == OP_ADD) || (i_op == OP_SUB)) begin
            w_ovf = (i_a[WIDTH-1] == w_bEffSign) && (w_res[WIDTH-1] != i_a[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE: if (w_accept && (i_op == OP_MUL)) w_stateNext = S_MUL;
            S_MUL:  if (w_mulDone) w_stateNext = S_IDLE;
            default: w_stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_prod   <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (w_accept && (i_op == OP_MUL)) begin
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_prod   <= '0;
            r_mplier <= i_b;
            r_cnt    <= '0;
        end else if ((r_state == S_MUL) && !w_mulDone) begin
            r_prod   <= w_prodAdd;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
        end
    end

    // A fresh load wins over retirement so back-to-back single-cycle ops stream without bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_zero     <= 1'b0;
            r_neg      <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (w_accept && (i_op != OP_MUL)) begin
            r_outValid <= 1'b1;
            r_result   <= w_res;
            r_carry    <= w_carry;
            r_zero     <= (w_res == '0);
            r_neg      <= w_res[WIDTH-1];
            r_ovf      <= w_ovf;
        end else if (w_mulDone) begin
            r_outValid <= 1'b1;
            r_result   <= r_prod[WIDTH-1:0];
            r_carry    <= 1'b0;
            r_zero     <= (r_prod[WIDTH-1:0] == '0);
            r_neg      <= r_prod[WIDTH-1];
            r_ovf      <= (r_prod[2*WIDTH-1:WIDTH] != '0);
        end else if (i_out_ready) begin
            r_outValid <= 1'b0;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_zero     <= 1'b0;
            r_neg      <= 1'b0;
            r_ovf      <= 1'b0;
        end
    end

    assign o_out_valid = r_outValid;
    assign o_result    = r_result;
    assign o_carry     = r_carry;
    assign o_zero      = r_zero;
    assign o_neg       = r_neg;
    assign o_ovf       = r_ovf;
    assign o_busy      = (r_state == S_MUL);

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: stimulus pushes expected results, a negedge monitor pops on handshake.
module tb_alu_mc;

    localparam int W = 16;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef struct packed {
        logic [W-1:0] res;
        logic [3:0]   flags;
    } exp_t;

    logic         clk;
    logic         rstN;
    logic         inValid;
    logic         inReady;
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic [2:0]   opSel;
    logic         outValid;
    logic         outReady;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
    logic         neg;
    logic         ovf;
    logic         busy;

    exp_t sbQ[$];
    int   checks = 0;
    int   errors = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rstN),
        .i_in_valid (inValid),
        .o_in_ready (inReady),
        .i_a        (opA),
        .i_b        (opB),
        .i_op       (opSel),
        .o_out_valid(outValid),
        .i_out_ready(outReady),
        .o_result   (result),
        .o_carry    (carry),
        .o_zero     (zero),
        .o_neg      (neg),
        .o_ovf      (ovf),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Flags are packed as {carry, zero, neg, ovf}.
    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] res, input logic [3:0] flags);
        int waited;
        exp_t e;
        e.res   = res;
        e.flags = flags;
        sbQ.push_back(e);
        opSel   = op;
        opA     = a;
        opB     = b;
        inValid = 1'b1;
        waited  = 0;
        while (!inReady && waited < 60) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!inReady) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout actual=in_ready_low required=in_ready_high");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        inValid = 1'b0;
    endtask

    // Monitor: a result transfers on the next rising edge whenever valid and ready are both high.
    always @(negedge clk) begin
        exp_t e;
        if (rstN && outValid && outReady) begin
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output actual=%h required=no_output", result);
            end else begin
                e = sbQ.pop_front();
                checkOutput("sb_result", result, e.res);
                checkOutput("sb_flags", W'({carry, zero, neg, ovf}), W'(e.flags));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        int k;
        rstN     = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b1;
        opA      = '0;
        opB      = '0;
        opSel    = OP_ADD;

        #12;
        checkOutput("rst_in_ready", W'(inReady), W'(1'b0));
        checkOutput("rst_out_valid", W'(outValid), W'(1'b0));
        checkOutput("rst_busy", W'(busy), W'(1'b0));
        checkOutput("rst_result", result, 16'h0000);
        checkOutput("rst_flags", W'({carry, zero, neg, ovf}), 16'h0000);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_in_ready", W'(inReady), W'(1'b1));

        // ADD wrap with carry, then SUB overflow and SUB borrow.
        applyStimulus(OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1100);
        checkOutput("add_latency", W'(outValid), W'(1'b1));
        applyStimulus(OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001);
        applyStimulus(OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 4'b1010);
        idleInputs();
        repeat (2) @(posedge clk);
        #1;

        // MUL whose product overflows the low half.
        applyStimulus(OP_MUL, 16'h0100, 16'h0100, 16'h0000, 4'b0101);
        idleInputs();
        checkOutput("mul_busy", W'(busy), W'(1'b1));
        checkOutput("mul_in_ready", W'(inReady), W'(1'b0));
        k = 1;
        while (!outValid && k < 40) begin
            @(posedge clk);
            #1;
            if (!outValid) k++;
        end
        checkOutput("mul_latency", W'(k), W'(17));
        checkOutput("mul_done_busy", W'(busy), W'(1'b0));
        repeat (2) @(posedge clk);
        #1;

        // MUL with a negative-looking low half and no overflow.
        applyStimulus(OP_MUL, 16'h00FF, 16'h0101, 16'hFFFF, 4'b0010);
        idleInputs();
        repeat (20) @(posedge clk);
        #1;

        // Output stall: result must hold and a new request must be ignored.
        outReady = 1'b0;
        applyStimulus(OP_XOR, 16'h00FF, 16'h0F0F, 16'h0FF0, 4'b0000);
        opSel = OP_ADD;
        opA   = 16'h1111;
        opB   = 16'h2222;
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_result", result, 16'h0FF0);
            checkOutput("hold_valid", W'(outValid), W'(1'b1));
            checkOutput("hold_in_ready", W'(inReady), W'(1'b0));
            @(posedge clk);
            #1;
        end
        idleInputs();
        outReady = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("stall_ignored_op", W'(outValid), W'(1'b0));

        // Back-to-back stream of single-cycle ops with the consumer always ready.
        applyStimulus(OP_ADD, 16'h1234, 16'h1111, 16'h2345, 4'b0000);
        checkOutput("stream_valid", W'(outValid), W'(1'b1));
        applyStimulus(OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0011);
        checkOutput("stream_valid", W'(outValid), W'(1'b1));
        applyStimulus(OP_ADD, 16'h8000, 16'h8000, 16'h0000, 4'b1101);
        checkOutput("stream_valid", W'(outValid), W'(1'b1));
        applyStimulus(OP_ADD, 16'h0F0F, 16'hF0F0, 16'hFFFF, 4'b0010);
        checkOutput("stream_valid", W'(outValid), W'(1'b1));
        applyStimulus(OP_AND, 16'hF0F0, 16'hFF00, 16'hF000, 4'b0010);
        checkOutput("stream_valid", W'(outValid), W'(1'b1));
        applyStimulus(OP_OR, 16'h000F, 16'h00F0, 16'h00FF, 4'b0000);
        checkOutput("stream_valid", W'(outValid), W'(1'b1));
        applyStimulus(OP_SRL, 16'h8000, 16'h00F4, 16'h0800, 4'b0000);
        checkOutput("stream_valid", W'(outValid), W'(1'b1));
        idleInputs();
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a multiply drops it entirely.
        applyStimulus(OP_MUL, 16'h0003, 16'h0005, 16'h000F, 4'b0000);
        idleInputs();
        repeat (6) @(posedge clk);
        #2;
        rstN = 1'b0;
        #1;
        sbQ.delete();
        checkOutput("abort_out_valid", W'(outValid), W'(1'b0));
        checkOutput("abort_busy", W'(busy), W'(1'b0));
        checkOutput("abort_result", result, 16'h0000);
        checkOutput("abort_in_ready", W'(inReady), W'(1'b0));
        #4;
        rstN = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rerst_in_ready", W'(inReady), W'(1'b1));
        checkOutput("rerst_out_valid", W'(outValid), W'(1'b0));
        applyStimulus(OP_SLL, 16'h0001, 16'h0013, 16'h0008, 4'b0000);
        idleInputs();
        repeat (25) @(posedge clk);
        #1;
        checkOutput("no_stale_mul", W'(outValid), W'(1'b0));
        checkOutput("queue_drained", W'(sbQ.size()), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
